// File: rtl/maquina_bebidas_param.sv
// Top-level beverage machine FSM: order latch, coin-by-coin payment, change/refund, timed dispensing.
// Optional macro DESCUENTO_EN adds the tarjeta_cliente input and a 12.5% loyalty discount.
module maquina_bebidas_param #(
    parameter int N_TIPOS    = 4,
    parameter int PRECIO_W   = 16,
    parameter int AZUCAR_MAX = 10,
    parameter int T_MOLIDO   = 8,
    parameter int T_LECHE    = 4,
    parameter int T_ESPUMA   = 4,
    parameter int T_TIMEOUT  = 1000,
    localparam int TW        = (N_TIPOS > 1) ? $clog2(N_TIPOS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pedido_valido,
    input  logic [TW-1:0]       tipo_cafe,
    input  logic [1:0]          tamano,
    input  logic [3:0]          azucar,
`ifdef DESCUENTO_EN
    input  logic                tarjeta_cliente,
`endif
    input  logic                moneda_valida,
    input  logic [PRECIO_W-1:0] moneda,
    input  logic                cancelar,
    output logic [PRECIO_W-1:0] precio_real,
    output logic [PRECIO_W-1:0] credito,
    output logic [PRECIO_W-1:0] vuelto,
    output logic                vuelto_valido,
    output logic                moneda_rechazo,
    output logic [3:0]          nivel_azucar,
    output logic                concentracion,
    output logic                leche,
    output logic                espuma,
    output logic                ocupado,
    output logic                bebida_lista,
    output logic [2:0]          estado_dbg
);

    // Strobes: pedido_valido and moneda_valida are single-cycle qualifiers with no ready;
    // a coin is credited only in COBRO, otherwise it is bounced via moneda_rechazo.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COBRO   = 3'd1,
        MOLIDO  = 3'd2,
        LECHE   = 3'd3,
        ESPUMA  = 3'd4,
        ENTREGA = 3'd5
    } estado_t;

    localparam int T_FASE = (T_MOLIDO > T_LECHE) ? ((T_MOLIDO > T_ESPUMA) ? T_MOLIDO : T_ESPUMA)
                                                 : ((T_LECHE > T_ESPUMA) ? T_LECHE : T_ESPUMA);
    localparam int T_MAX  = (T_FASE > T_TIMEOUT) ? T_FASE : T_TIMEOUT;
    localparam int CW     = $clog2(T_MAX + 1);
    localparam int EW     = PRECIO_W + 2;

    estado_t             estado, estado_sig;
    logic [CW-1:0]       cuenta, cuenta_sig;
    logic [TW-1:0]       tipo_q;
    logic [31:0]         tipo_ext;
    logic                con_leche, con_espuma;

    logic [EW-1:0]       base_ext, precio_ext;
    logic [PRECIO_W-1:0] precio_sat, precio_nuevo;
    logic [3:0]          azucar_sat;
    logic [PRECIO_W:0]   suma_ext;
    logic [PRECIO_W-1:0] credito_act;

    logic [PRECIO_W-1:0] credito_sig, vuelto_sig;
    logic                vuelto_valido_sig, rechazo_sig, latch_orden;

    assign estado_dbg = estado;

    // Price grows 2 bits wider than money so the size multiplier cannot wrap before saturation.
    always_comb begin
        base_ext   = EW'(1000) + EW'(250) * EW'(tipo_cafe);
        precio_ext = base_ext + (base_ext >> 1) * EW'(tamano);
        precio_sat = (|precio_ext[EW-1:PRECIO_W]) ? '1 : precio_ext[PRECIO_W-1:0];
`ifdef DESCUENTO_EN
        precio_nuevo = tarjeta_cliente ? (precio_sat - (precio_sat >> 3)) : precio_sat;
`else
        precio_nuevo = precio_sat;
`endif
        azucar_sat = (azucar > 4'(AZUCAR_MAX)) ? 4'(AZUCAR_MAX) : azucar;
    end

    always_comb begin
        suma_ext    = {1'b0, credito} + {1'b0, moneda};
        credito_act = credito;
        if (moneda_valida) begin
            credito_act = suma_ext[PRECIO_W] ? '1 : suma_ext[PRECIO_W-1:0];
        end
    end

    assign tipo_ext   = 32'(tipo_q);
    assign con_leche  = (tipo_ext == 32'd2) || (tipo_ext == 32'd3);
    assign con_espuma = (tipo_ext == 32'd3);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= IDLE;
            cuenta <= '0;
        end else begin
            estado <= estado_sig;
            cuenta <= cuenta_sig;
        end
    end

    always_comb begin
        estado_sig        = estado;
        cuenta_sig        = cuenta;
        credito_sig       = credito;
        vuelto_sig        = vuelto;
        vuelto_valido_sig = 1'b0;
        rechazo_sig       = moneda_valida && (estado != COBRO);
        latch_orden       = 1'b0;
        case (estado)
            IDLE: begin
                if (pedido_valido && (tamano != 2'd3)) begin
                    latch_orden = 1'b1;
                    estado_sig  = COBRO;
                    cuenta_sig  = '0;
                    credito_sig = '0;
                end
            end
            COBRO: begin
                credito_sig = credito_act;
                cuenta_sig  = moneda_valida ? '0 : cuenta + 1'b1;
                // Cancel wins over payment so a coin arriving with cancel is refunded, not spent.
                if (cancelar || (!moneda_valida && (cuenta == CW'(T_TIMEOUT - 1)))) begin
                    vuelto_sig        = credito_act;
                    vuelto_valido_sig = 1'b1;
                    credito_sig       = '0;
                    cuenta_sig        = '0;
                    estado_sig        = IDLE;
                end else if (credito_act >= precio_real) begin
                    vuelto_sig        = credito_act - precio_real;
                    vuelto_valido_sig = 1'b1;
                    credito_sig       = '0;
                    cuenta_sig        = '0;
                    estado_sig        = MOLIDO;
                end
            end
            MOLIDO: begin
                cuenta_sig = cuenta + 1'b1;
                if (cuenta == CW'(T_MOLIDO - 1)) begin
                    cuenta_sig = '0;
                    estado_sig = con_leche ? LECHE : ENTREGA;
                end
            end
            LECHE: begin
                cuenta_sig = cuenta + 1'b1;
                if (cuenta == CW'(T_LECHE - 1)) begin
                    cuenta_sig = '0;
                    estado_sig = con_espuma ? ESPUMA : ENTREGA;
                end
            end
            ESPUMA: begin
                cuenta_sig = cuenta + 1'b1;
                if (cuenta == CW'(T_ESPUMA - 1)) begin
                    cuenta_sig = '0;
                    estado_sig = ENTREGA;
                end
            end
            ENTREGA: begin
                cuenta_sig = '0;
                estado_sig = IDLE;
            end
            default: begin
                cuenta_sig = '0;
                estado_sig = IDLE;
            end
        endcase
    end

    // Phase outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            precio_real    <= '0;
            credito        <= '0;
            vuelto         <= '0;
            vuelto_valido  <= 1'b0;
            moneda_rechazo <= 1'b0;
            nivel_azucar   <= '0;
            concentracion  <= 1'b0;
            tipo_q         <= '0;
            leche          <= 1'b0;
            espuma         <= 1'b0;
            ocupado        <= 1'b0;
            bebida_lista   <= 1'b0;
        end else begin
            credito        <= credito_sig;
            vuelto         <= vuelto_sig;
            vuelto_valido  <= vuelto_valido_sig;
            moneda_rechazo <= rechazo_sig;
            leche          <= (estado_sig == LECHE);
            espuma         <= (estado_sig == ESPUMA);
            ocupado        <= (estado_sig != IDLE);
            bebida_lista   <= (estado_sig == ENTREGA);
            if (latch_orden) begin
                precio_real   <= precio_nuevo;
                nivel_azucar  <= azucar_sat;
                tipo_q        <= tipo_cafe;
                concentracion <= (32'(tipo_cafe) == 32'd0);
            end
        end
    end

endmodule

// File: tb/tb_maquina_bebidas_param.sv
// Directed bench for maquina_bebidas_param: hand-computed prices, change, phase timing and refunds.
module tb_maquina_bebidas_param;

    localparam int PRECIO_W  = 16;
    localparam int TW        = 2;
    localparam int T_MOLIDO  = 8;
    localparam int T_LECHE   = 4;
    localparam int T_ESPUMA  = 4;
    localparam int T_TIMEOUT = 1000;

    logic                clock;
    logic                reset;
    logic                pedido_valido;
    logic [TW-1:0]       tipo_cafe;
    logic [1:0]          tamano;
    logic [3:0]          azucar;
`ifdef DESCUENTO_EN
    logic                tarjeta_cliente;
`endif
    logic                moneda_valida;
    logic [PRECIO_W-1:0] moneda;
    logic                cancelar;
    logic [PRECIO_W-1:0] precio_real;
    logic [PRECIO_W-1:0] credito;
    logic [PRECIO_W-1:0] vuelto;
    logic                vuelto_valido;
    logic                moneda_rechazo;
    logic [3:0]          nivel_azucar;
    logic                concentracion;
    logic                leche;
    logic                espuma;
    logic                ocupado;
    logic                bebida_lista;
    logic [2:0]          estado_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [PRECIO_W-1:0] exp_q[$];

    maquina_bebidas_param dut (
        .clock          (clock),
        .reset          (reset),
        .pedido_valido  (pedido_valido),
        .tipo_cafe      (tipo_cafe),
        .tamano         (tamano),
        .azucar         (azucar),
`ifdef DESCUENTO_EN
        .tarjeta_cliente(tarjeta_cliente),
`endif
        .moneda_valida  (moneda_valida),
        .moneda         (moneda),
        .cancelar       (cancelar),
        .precio_real    (precio_real),
        .credito        (credito),
        .vuelto         (vuelto),
        .vuelto_valido  (vuelto_valido),
        .moneda_rechazo (moneda_rechazo),
        .nivel_azucar   (nivel_azucar),
        .concentracion  (concentracion),
        .leche          (leche),
        .espuma         (espuma),
        .ocupado        (ocupado),
        .bebida_lista   (bebida_lista),
        .estado_dbg     (estado_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pedir(input int t, input int tam, input int az, input logic tarjeta);
        tipo_cafe     = TW'(t);
        tamano        = 2'(tam);
        azucar        = 4'(az);
`ifdef DESCUENTO_EN
        tarjeta_cliente = tarjeta;
`else
        if (tarjeta) $display("note: card ignored without discount build");
`endif
        pedido_valido = 1'b1;
        tick();
        pedido_valido = 1'b0;
`ifdef DESCUENTO_EN
        tarjeta_cliente = 1'b0;
`endif
    endtask

    task automatic moneda_in(input int valor);
        moneda_valida = 1'b1;
        moneda        = PRECIO_W'(valor);
        tick();
        moneda_valida = 1'b0;
        moneda        = '0;
    endtask

    task automatic cancelar_in();
        cancelar = 1'b1;
        tick();
        cancelar = 1'b0;
    endtask

    task automatic wait_entrega(output int ciclos, output int n_leche, output int n_espuma,
                                output int ini_leche, output int ini_espuma);
        ciclos = 0; n_leche = 0; n_espuma = 0; ini_leche = 0; ini_espuma = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (leche) begin
                n_leche++;
                if (ini_leche == 0) ini_leche = i;
            end
            if (espuma) begin
                n_espuma++;
                if (ini_espuma == 0) ini_espuma = i;
            end
            if (bebida_lista) begin
                ciclos = i;
                break;
            end
        end
    endtask

    // Change scoreboard: every vuelto_valido pulse must match the oldest expected amount.
    always begin
        @(posedge clock);
        #2;
        if (reset && vuelto_valido) begin
            if (exp_q.size() == 0) check_val("vuelto_pendiente", 32'(exp_q.size()), 32'd1);
            else check_val("vuelto", 32'(vuelto), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int ciclos, nl, ne, il, ie, k;
        reset         = 1'b0;
        pedido_valido = 1'b0;
        tipo_cafe     = '0;
        tamano        = '0;
        azucar        = '0;
`ifdef DESCUENTO_EN
        tarjeta_cliente = 1'b0;
`endif
        moneda_valida = 1'b0;
        moneda        = '0;
        cancelar      = 1'b0;
        repeat (3) tick();
        check_val("rst_estado", 32'(estado_dbg), 32'd0);
        check_val("rst_ocupado", 32'(ocupado), 32'd0);
        check_val("rst_precio", 32'(precio_real), 32'd0);
        reset = 1'b1;
        tick();

        // Espresso, small, sugar clipped 15 -> 10, exact payment in two coins.
        pedir(0, 0, 15, 1'b0);
        check_val("esp_estado", 32'(estado_dbg), 32'd1);
        check_val("esp_precio", 32'(precio_real), 32'd1000);
        check_val("esp_azucar", 32'(nivel_azucar), 32'd10);
        check_val("esp_conc", 32'(concentracion), 32'd1);
        check_val("esp_ocupado", 32'(ocupado), 32'd1);
        moneda_in(500);
        check_val("esp_credito", 32'(credito), 32'd500);
        exp_q.push_back(16'd0);
        moneda_in(500);
        check_val("esp_pago_estado", 32'(estado_dbg), 32'd2);
        check_val("esp_pago_credito", 32'(credito), 32'd0);
        wait_entrega(ciclos, nl, ne, il, ie);
        check_val("esp_ciclos", 32'(ciclos), 32'(T_MOLIDO));
        check_val("esp_leche", 32'(nl), 32'd0);
        tick();
        check_val("esp_lista_pulso", 32'(bebida_lista), 32'd0);
        check_val("esp_fin_ocupado", 32'(ocupado), 32'd0);

        // Cappuccino, large: 1750 + 875*2 = 3500; pay 4000 -> change 500.
        pedir(3, 2, 5, 1'b0);
        check_val("cap_precio", 32'(precio_real), 32'd3500);
        check_val("cap_conc", 32'(concentracion), 32'd0);
        moneda_in(2000);
        check_val("cap_credito", 32'(credito), 32'd2000);
        exp_q.push_back(16'd500);
        moneda_in(2000);
        check_val("cap_pago_leche", 32'(leche), 32'd0);
        wait_entrega(ciclos, nl, ne, il, ie);
        check_val("cap_ciclos", 32'(ciclos), 32'(T_MOLIDO + T_LECHE + T_ESPUMA));
        check_val("cap_n_leche", 32'(nl), 32'(T_LECHE));
        check_val("cap_n_espuma", 32'(ne), 32'(T_ESPUMA));
        check_val("cap_ini_leche", 32'(il), 32'(T_MOLIDO));
        check_val("cap_ini_espuma", 32'(ie), 32'(T_MOLIDO + T_LECHE));
        tick();

        // Latte, medium: 1500 + 750 = 2250; cancel after 1000 -> refund 1000.
        pedir(2, 1, 3, 1'b0);
        check_val("lat_precio", 32'(precio_real), 32'd2250);
        check_val("lat_azucar", 32'(nivel_azucar), 32'd3);
        moneda_in(1000);
        exp_q.push_back(16'd1000);
        cancelar_in();
        check_val("lat_cancel_estado", 32'(estado_dbg), 32'd0);
        check_val("lat_cancel_credito", 32'(credito), 32'd0);
        repeat (3) tick();
        check_val("lat_sin_leche", 32'(leche), 32'd0);
        check_val("lat_ocupado", 32'(ocupado), 32'd0);

        // Americano; coin together with cancel is credited then refunded (300 + 2000).
        pedir(1, 0, 0, 1'b0);
        check_val("ame_precio", 32'(precio_real), 32'd1250);
        moneda_in(300);
        exp_q.push_back(16'd2300);
        moneda_valida = 1'b1;
        moneda        = 16'd2000;
        cancelar      = 1'b1;
        tick();
        moneda_valida = 1'b0;
        moneda        = '0;
        cancelar      = 1'b0;
        check_val("ame_cancel_estado", 32'(estado_dbg), 32'd0);

        // Coin during MOLIDO is bounced, credit untouched.
        pedir(1, 0, 0, 1'b0);
        exp_q.push_back(16'd0);
        moneda_in(1250);
        check_val("rch_estado", 32'(estado_dbg), 32'd2);
        moneda_in(300);
        check_val("rch_pulso", 32'(moneda_rechazo), 32'd1);
        check_val("rch_credito", 32'(credito), 32'd0);
        tick();
        check_val("rch_fin", 32'(moneda_rechazo), 32'd0);
        wait_entrega(ciclos, nl, ne, il, ie);
        check_val("rch_ciclos", 32'(ciclos), 32'(T_MOLIDO - 2));
        tick();

        // Invalid size is ignored and previous order stays latched.
        pedir(0, 3, 7, 1'b0);
        check_val("inv_estado", 32'(estado_dbg), 32'd0);
        check_val("inv_precio", 32'(precio_real), 32'd1250);
        check_val("inv_azucar", 32'(nivel_azucar), 32'd0);
        moneda_in(100);
        check_val("idle_rechazo", 32'(moneda_rechazo), 32'd1);
        check_val("idle_credito", 32'(credito), 32'd0);

        // Timeout refund after T_TIMEOUT idle cycles.
        pedir(0, 0, 0, 1'b0);
        moneda_in(200);
        check_val("tmo_credito", 32'(credito), 32'd200);
        exp_q.push_back(16'd200);
        k = 0;
        for (int i = 1; i <= T_TIMEOUT + 100; i++) begin
            tick();
            if (vuelto_valido) begin
                k = i;
                break;
            end
        end
        check_val("tmo_ciclos", 32'(k), 32'(T_TIMEOUT));
        check_val("tmo_estado", 32'(estado_dbg), 32'd0);

        // Large coin pays at once; sugar exactly at the ceiling.
        pedir(0, 0, 10, 1'b0);
        check_val("max_azucar", 32'(nivel_azucar), 32'd10);
        exp_q.push_back(16'd64535);
        moneda_in(65535);
        check_val("max_estado", 32'(estado_dbg), 32'd2);
        wait_entrega(ciclos, nl, ne, il, ie);
        tick();

`ifdef DESCUENTO_EN
        // 1250 - (1250 >> 3) = 1094.
        pedir(1, 0, 0, 1'b1);
        check_val("dsc_precio", 32'(precio_real), 32'd1094);
        exp_q.push_back(16'd0);
        cancelar_in();
`endif

        // Reset asserted mid-COBRO clears everything without a clock edge.
        pedir(3, 0, 4, 1'b0);
        moneda_in(500);
        check_val("rst2_credito_pre", 32'(credito), 32'd500);
        reset = 1'b0;
        #1;
        check_val("rst2_estado", 32'(estado_dbg), 32'd0);
        check_val("rst2_ocupado", 32'(ocupado), 32'd0);
        check_val("rst2_credito", 32'(credito), 32'd0);
        check_val("rst2_precio", 32'(precio_real), 32'd0);
        check_val("rst2_azucar", 32'(nivel_azucar), 32'd0);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        check_val("rst2_post", 32'(estado_dbg), 32'd0);
        check_val("cola_vacia", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
